// File: rtl/bytebeat_pwm_dac.sv
`default_nettype none
// ============================================================================
//  Module   : bytebeat_pwm_dac
//  Purpose  : 8-bit sample to single-bit PWM audio stage. Samples arrive over
//             a valid/ready handshake into a 2-entry FIFO. Each sample plays
//             for FRAMES PWM frames of 256 cycles. A sticky flag records any
//             sample boundary that found the FIFO empty.
//  Revision : 1.0  initial release
// ============================================================================
module bytebeat_pwm_dac #(
   parameter int FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       clr_underrun,
   output logic       pwm_out,
   output logic [7:0] cur_sample,
   output logic       underrun
);

   // A single frame per sample still needs a 1-bit frame counter.
   localparam int                    c_fcnt_w = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam logic [c_fcnt_w-1:0]   c_flast  = c_fcnt_w'(FRAMES - 1);
   localparam logic [c_fcnt_w-1:0]   c_fone   = c_fcnt_w'(1);
   localparam logic [7:0]            c_mid    = 8'h80;

   logic [7:0]          r_pcnt;
   logic [c_fcnt_w-1:0] r_fcnt;
   logic [7:0]          r_cur;
   logic                r_pwm;
   logic                r_underrun;
   logic [1:0]          r_count;
   logic [7:0]          r_fifo [2];

   logic                w_push;
   logic                w_boundary;
   logic                w_pop;
   logic                w_underrun_set;

   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign s_ready        = (r_count != 2'd2);
   assign w_push         = s_valid && s_ready;
   assign w_boundary     = ena && (r_pcnt == 8'hFF) && (r_fcnt == c_flast);
   assign w_pop          = w_boundary && (r_count != 2'd0);
   assign w_underrun_set = w_boundary && (r_count == 2'd0);

   assign pwm_out    = r_pwm;
   assign cur_sample = r_cur;
   assign underrun   = r_underrun;

   // PWM position and frame-within-sample counters advance only while enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= 8'd0;
         r_fcnt <= '0;
      end else if (ena) begin
         r_pcnt <= r_pcnt + 8'd1;
         if (r_pcnt == 8'hFF) begin
            r_fcnt <= (r_fcnt == c_flast) ? '0 : r_fcnt + c_fone;
         end
      end
   end

   // Two-entry FIFO; head is always entry 0. A push alongside a pop can only
   // happen with one entry held, so the new sample lands directly in the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= 2'd0;
         r_fifo[0] <= 8'd0;
         r_fifo[1] <= 8'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               r_fifo[r_count[0]] <= s_data;
               r_count            <= r_count + 2'd1;
            end
            2'b01: begin
               r_fifo[0] <= r_fifo[1];
               r_count   <= r_count - 2'd1;
            end
            2'b11: begin
               r_fifo[0] <= s_data;
            end
            default: begin
            end
         endcase
      end
   end

   // Current sample is replaced only by a real pop; an empty boundary holds it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur <= c_mid;
      end else if (w_pop) begin
         r_cur <= r_fifo[0];
      end
   end

   // Sticky underrun; a set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_underrun <= 1'b0;
      end else if (w_underrun_set) begin
         r_underrun <= 1'b1;
      end else if (clr_underrun) begin
         r_underrun <= 1'b0;
      end
   end

   // Registered PWM compare: high for the first cur_sample cycles of a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= 1'b0;
      end else begin
         r_pwm <= ena && (r_pcnt < r_cur);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bytebeat_pwm_dac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bytebeat_pwm_dac
//  Purpose  : Self-checking bench for bytebeat_pwm_dac. Two instances share
//             one stimulus stream: one plays a sample per frame, the other
//             plays each sample for three frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bytebeat_pwm_dac;

   localparam int FR_A = 1;
   localparam int FR_B = 3;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] s_data;
   logic       s_valid;
   logic       clr_underrun;

   logic       rdy_a, pwm_a, und_a;
   logic [7:0] cur_a;
   logic       rdy_b, pwm_b, und_b;
   logic [7:0] cur_b;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   bytebeat_pwm_dac #(.FRAMES(FR_A)) dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (rdy_a),
      .clr_underrun (clr_underrun),
      .pwm_out      (pwm_a),
      .cur_sample   (cur_a),
      .underrun     (und_a)
   );

   bytebeat_pwm_dac #(.FRAMES(FR_B)) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (rdy_b),
      .clr_underrun (clr_underrun),
      .pwm_out      (pwm_b),
      .cur_sample   (cur_b),
      .underrun     (und_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // ------------------------------------------------------------------------
   // Reference model: a free-running phase count of enabled cycles within a
   // sample period, a small buffer, and the playing sample.
   // ------------------------------------------------------------------------
   int         m_ph  [2];
   int         m_cnt [2];
   logic [7:0] m_q   [2][2];
   logic [7:0] m_cur [2];
   logic       m_pwm [2];
   logic       m_und [2];

   always @(posedge clk or negedge rst_n) begin
      int         f, pre, cnt, nph;
      bit         bnd, psh, pp, npwm, nund;
      logic [7:0] q0, q1, ncur;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_ph[k]   <= 0;
            m_cnt[k]  <= 0;
            m_q[k][0] <= 8'd0;
            m_q[k][1] <= 8'd0;
            m_cur[k]  <= 8'h80;
            m_pwm[k]  <= 1'b0;
            m_und[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            f    = (k == 0) ? FR_A : FR_B;
            pre  = m_cnt[k];
            bnd  = ena && (m_ph[k] == 256 * f - 1);
            psh  = s_valid && (pre < 2);
            pp   = bnd && (pre > 0);
            npwm = ena && ((m_ph[k] % 256) < int'(m_cur[k]));
            nph  = ena ? (m_ph[k] + 1) % (256 * f) : m_ph[k];
            q0   = m_q[k][0];
            q1   = m_q[k][1];
            cnt  = pre;
            ncur = m_cur[k];
            if (pp) begin
               ncur = q0;
               q0   = q1;
               cnt  = cnt - 1;
            end
            if (psh) begin
               if (cnt == 0) q0 = s_data;
               else          q1 = s_data;
               cnt = cnt + 1;
            end
            nund = (bnd && pre == 0) ? 1'b1 : (clr_underrun ? 1'b0 : m_und[k]);
            m_ph[k]   <= nph;
            m_cnt[k]  <= cnt;
            m_q[k][0] <= q0;
            m_q[k][1] <= q1;
            m_cur[k]  <= ncur;
            m_pwm[k]  <= npwm;
            m_und[k]  <= nund;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model pwm_a",   32'(pwm_a), 32'(m_pwm[0]));
         chk("model cur_a",   32'(cur_a), 32'(m_cur[0]));
         chk("model und_a",   32'(und_a), 32'(m_und[0]));
         chk("model ready_a", 32'(rdy_a), 32'(m_cnt[0] < 2));
         chk("model pwm_b",   32'(pwm_b), 32'(m_pwm[1]));
         chk("model cur_b",   32'(cur_b), 32'(m_cur[1]));
         chk("model und_b",   32'(und_b), 32'(m_und[1]));
         chk("model ready_b", 32'(rdy_b), 32'(m_cnt[1] < 2));
      end
   end

   // ------------------------------------------------------------------------
   // Directed stimulus with hand-computed expectations.
   // ------------------------------------------------------------------------
   initial begin
      int h, hb, pv, pos, fr;
      int hcnt [4];
      int bad  [4];
      int exph [4];
      exph[0] = 128; exph[1] = 64; exph[2] = 0; exph[3] = 255;

      rst_n = 1'b0; ena = 1'b0; s_valid = 1'b0; s_data = 8'd0; clr_underrun = 1'b0;
      repeat (3) step();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk("reset cur", 32'(cur_a), 32'h80);
      chk("reset pwm", 32'(pwm_a), 32'd0);
      chk("reset und", 32'(und_a), 32'd0);
      chk("reset rdy", 32'(rdy_a), 32'd1);

      // Mid-scale silence: 128 highs in the first 256 enabled cycles.
      ena = 1'b1;
      h = 0; hb = 0;
      for (int e = 1; e <= 256; e++) begin
         step();
         if (pwm_a) h++;
         if (pwm_b) hb++;
      end
      chk("first frame highs a", 32'(h), 32'd128);
      chk("first frame highs b", 32'(hb), 32'd128);
      chk("first boundary und a", 32'(und_a), 32'd1);
      chk("first boundary cur a", 32'(cur_a), 32'h80);
      chk("no boundary yet und b", 32'(und_b), 32'd0);

      // Back-pressure while paused, plus underrun clear.
      ena = 1'b0; s_valid = 1'b1; s_data = 8'h40;
      step();
      chk("bp rdy after 1", 32'(rdy_a), 32'd1);
      s_data = 8'h00;
      step();
      chk("bp rdy after 2 a", 32'(rdy_a), 32'd0);
      chk("bp rdy after 2 b", 32'(rdy_b), 32'd0);
      s_data = 8'hFF; clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("clear und a", 32'(und_a), 32'd0);
      chk("bp still full", 32'(rdy_a), 32'd0);

      // Duty cycle frames on the one-frame instance: 128, 64, 0, 255.
      ena = 1'b1;
      for (int i = 0; i < 4; i++) begin
         hcnt[i] = 0;
         bad[i]  = 0;
      end
      for (int e = 1; e <= 1024; e++) begin
         step();
         pos = (e - 1) % 256;
         fr  = (e - 1) / 256;
         if (pwm_a) hcnt[fr]++;
         if (pwm_a != (pos < exph[fr])) bad[fr]++;
         if (e == 256) begin
            chk("pop frees slot", 32'(rdy_a), 32'd1);
            chk("pop 0x40", 32'(cur_a), 32'h40);
         end
         if (e == 257) begin
            chk("third accepted", 32'(rdy_a), 32'd0);
            s_valid = 1'b0;
         end
         if (e == 511) chk("b before boundary", 32'(cur_b), 32'h80);
         if (e == 512) chk("b at boundary", 32'(cur_b), 32'h40);
         if (e == 1024) begin
            chk("drain und", 32'(und_a), 32'd1);
            chk("drain cur holds", 32'(cur_a), 32'hFF);
         end
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("duty highs frame%0d", i), 32'(hcnt[i]), 32'(exph[i]));
         chk($sformatf("duty contiguous frame%0d", i), 32'(bad[i]), 32'd0);
      end

      // Clear, then set and clear in the same cycle.
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("und cleared", 32'(und_a), 32'd0);
      repeat (254) step();
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("set beats clear", 32'(und_a), 32'd1);
      chk("underrun holds cur", 32'(cur_a), 32'hFF);

      // Push on the pop cycle with one entry held.
      s_valid = 1'b1; s_data = 8'h11;
      step();
      s_valid = 1'b0;
      chk("one held rdy", 32'(rdy_a), 32'd1);
      repeat (254) step();
      s_valid = 1'b1; s_data = 8'h22;
      step();
      s_valid = 1'b0;
      chk("push+pop cur", 32'(cur_a), 32'h11);
      chk("push+pop rdy", 32'(rdy_a), 32'd1);
      repeat (255) step();
      chk("0x22 not yet", 32'(cur_a), 32'h11);
      step();
      chk("0x22 plays", 32'(cur_a), 32'h22);

      // Pause for 50 cycles after 20 enabled cycles of a 0x22 frame.
      h = 0; pv = 0;
      repeat (20) begin
         step();
         if (pwm_a) h++;
      end
      ena = 1'b0; s_valid = 1'b1; s_data = 8'h55;
      for (int i = 0; i < 50; i++) begin
         step();
         s_valid = 1'b0;
         if (pwm_a) pv++;
      end
      ena = 1'b1;
      for (int i = 0; i < 236; i++) begin
         step();
         if (pwm_a) h++;
         if (i == 234) chk("pause boundary late", 32'(cur_a), 32'h22);
         if (i == 235) chk("pause boundary on time", 32'(cur_a), 32'h55);
      end
      chk("pause pwm low", 32'(pv), 32'd0);
      chk("pause frame highs", 32'(h), 32'd34);

      // Reset mid-stream with samples buffered.
      s_valid = 1'b1; s_data = 8'h99;
      step();
      step();
      s_valid = 1'b0;
      repeat (37) step();
      #3 rst_n = 1'b0;
      #1;
      chk("async reset cur", 32'(cur_a), 32'h80);
      chk("async reset pwm", 32'(pwm_a), 32'd0);
      chk("async reset und", 32'(und_a), 32'd0);
      chk("async reset rdy", 32'(rdy_a), 32'd1);
      repeat (3) step();
      rst_n = 1'b1;
      h = 0;
      for (int e = 1; e <= 256; e++) begin
         step();
         if (pwm_a) h++;
      end
      chk("post reset highs", 32'(h), 32'd128);
      chk("post reset fifo discarded cur", 32'(cur_a), 32'h80);
      chk("post reset fifo discarded und", 32'(und_a), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bytebeat_pwm_dac.md
# bytebeat_pwm_dac

Audio output stage downstream of the bytebeat sample generator. It accepts 8-bit unsigned samples through a valid/ready handshake into a 2-entry buffer. Each sample plays for a fixed number of 256-cycle PWM frames, and the block drives a single-bit PWM pin for an external RC filter. Buffer underruns are flagged so firmware and tests can detect a generator that cannot keep pace.

## Interface
Parameters:
- FRAMES, default 4: PWM frames per sample, legal range 1..256. Sample rate is clk/(256*FRAMES).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable. Low freezes playback.
- s_data  in  8  unsigned sample from the generator.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  buffer can accept a sample this cycle.
- clr_underrun  in  1  synchronous clear of underrun.
- pwm_out  out  1  PWM audio output, registered.
- cur_sample  out  8  sample currently being played.
- underrun  out  1  sticky underrun flag.

## Operation
- Buffer: 2-entry FIFO, with occupancy `count` in 0..2.
  - s_ready = (count < 2), combinational from registered state only. It never depends on a pop in the same cycle.
  - A push occurs when s_valid && s_ready. A push is accepted regardless of ena.
- PWM counter `pcnt` (8 bit) increments by 1 on each cycle with ena=1 and wraps 255->0.
- Frame counter `fcnt` (0..FRAMES-1):
  - increments when pcnt==255 and ena=1.
  - wraps to 0 after FRAMES-1.
  - has width max(1,$clog2(FRAMES)).
- Sample boundary is the cycle where ena=1, pcnt==255 and fcnt==FRAMES-1:
  - If count>0: pop the FIFO head into cur_sample.
  - If count==0: cur_sample holds and underrun is set to 1.
- Simultaneous push and pop:
  - count==1: count stays 1, and the new data becomes the head after the pop.
  - count==0: only the underrun path applies. The pushed sample enters the FIFO; it does not bypass to cur_sample.
  - count==2: no push is possible because s_ready=0.
- underrun is set at an empty boundary and stays 1 until clr_underrun=1. If clear and set happen in the same cycle, set wins.
- pwm_out next value = ena && (pcnt < cur_sample), as an unsigned compare.
  - Sample 0x00 gives a constant 0.
  - Sample 0xFF gives 255 high cycles out of 256.
- ena=0: pcnt, fcnt and cur_sample hold, there are no pops, and pwm_out is 0 from the next edge.
- Reset (rst_n low, asynchronous):
  - pcnt=0, fcnt=0, FIFO empty (count=0).
  - cur_sample=0x80 (mid-scale silence), pwm_out=0, underrun=0.
  - s_ready therefore reads 1 after reset.
- Reset asserted mid-frame discards the buffered samples and the current sample immediately.

## Timing
- Push latency: a sample accepted at edge N is visible in the FIFO at N+1 and is eligible for the next boundary at or after N+1.
- Pop: at the boundary edge, cur_sample is updated and pcnt goes to 0. The first pwm_out of the new sample appears one edge later, reflecting pcnt==0.
- The PWM period is exactly 256 enabled cycles. The high time in a frame is exactly cur_sample cycles, starting at frame start.
- After reset release with a continuous ena=1, the first boundary is the 256*FRAMES-th enabled edge.
- Throughput: 1 sample per 256*FRAMES enabled cycles. With count==2 the generator is back-pressured until the next pop.

## Test plan
- Reset: hold rst_n=0 mid-stream, then release.
  - Required: cur_sample=0x80, pwm_out=0, underrun=0, s_ready=1.
  - Required: the first 256 enabled cycles produce 128 pwm_out highs.
- Duty cycle with FRAMES=1: push 0x40, 0x00, 0xFF.
  - Required: successive frames carry 64, 0 and 255 high cycles, each contiguous from the frame start.
- Back-pressure: with ena=0, push 3 samples back-to-back.
  - Required: the first two are accepted, s_ready=0 on the third cycle, and the third is accepted only after a pop once ena=1.
- Underrun: let the FIFO drain.
  - Required: at the boundary, underrun=1 and cur_sample holds its last value.
  - Required: clr_underrun clears it, and a set-and-clear in the same cycle leaves 1.
- Push at the boundary with count==1: push 0x22 on the pop cycle while the head is 0x11.
  - Required: cur_sample=0x11, count stays 1, and 0x22 plays at the following boundary.
- ena pause: drop ena for 50 cycles mid-frame.
  - Required: pwm_out=0 during the pause, pcnt and fcnt are frozen, and the frame resumes with no lost or extra cycles.
